ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable,
//  0xFF reset) from the FPGA to the keyboard over the shared PS2_CLK/PS2_DATA lines.
//  Drives the lines open-drain: an OE high pulls the pad low, an OE low releases it.
//  Sits beside the existing keyboard receiver. The top level ties the pads as inout, with
//  pad = OE ? 1'b0 : 1'bz, and feeds the pad values back in.
//  The receiver must ignore traffic while busy=1.
// PARAMETERS
//  INHIBIT_CYCLES  5000    CLK cycles PS2_CLK is held low before the request (100 us @ 50 MHz)
//  TIMEOUT_CYCLES  750000  max CLK cycles from clock release to ACK seen (15 ms @ 50 MHz)
// PORTS
//  CLK          in   1  board clock
//  RST          in   1  asynchronous, active-high reset
//  tx_data      in   8  command byte, sampled on accept
//  tx_valid     in   1  request to send tx_data
//  tx_ready     out  1  block idle; transfer accepted when tx_valid & tx_ready
//  busy         out  1  transfer in progress (~tx_ready)
//  tx_done      out  1  1-cycle pulse: byte sent and ACKed by device
//  tx_error     out  1  1-cycle pulse: timeout or missing ACK
//  PS2_CLK      in   1  keyboard clock pad value (asynchronous)
//  PS2_DATA     in   1  keyboard data pad value (asynchronous)
//  PS2_CLK_OE   out  1  1 = pull PS2_CLK low
//  PS2_DATA_OE  out  1  1 = pull PS2_DATA low
// BEHAVIOUR
//  Reset values and reset mid-transfer
//  - RST (async, at any time): state=IDLE, both OE=0, tx_ready=1, busy=0, tx_done=0,
//    tx_error=0, counters cleared.
//  - Reset mid-transfer therefore releases both lines immediately.
//  Input synchronisation and edge detect
//  - PS2_CLK and PS2_DATA each pass through a 2-FF synchroniser.
//  - A falling edge (fe) = synced PS2_CLK was 1 last cycle and is 0 now.
//  Accept
//  - On tx_valid & tx_ready: latch the byte.
//  - Latch parity = ~^tx_data (odd parity).
//  - Enter INHIBIT on the next edge.
//  - tx_valid while busy is ignored; there is no queue.
//  FSM
//  - IDLE: CLK_OE=0, DATA_OE=0.
//  - INHIBIT: CLK_OE=1 for INHIBIT_CYCLES cycles. On the last cycle, DATA_OE goes to 1
//    (start bit).
//  - REQ: CLK_OE=1, DATA_OE=1 for exactly 1 cycle. Then CLK_OE=0, the timeout counter
//    starts and the block enters SHIFT with bit index 0.
//  - SHIFT: on each fe, DATA_OE <= ~bit, registered the cycle after fe is seen.
//    - Data bits go out LSB first for fe 1..8.
//    - fe 9 drives the parity bit.
//    - fe 10 sets DATA_OE=0 (stop bit, line released).
//    - After fe 10 the block enters ACK.
//  - ACK: on the next fe, sample synced PS2_DATA.
//    - 0 → WAIT_IDLE.
//    - 1 → ERROR.
//  - WAIT_IDLE: wait until synced PS2_CLK=1 and PS2_DATA=1. Then pulse tx_done and enter IDLE.
//  - ERROR: pulse tx_error for 1 cycle, both OE=0, enter IDLE.
//  Timeout
//  - If the counter reaches TIMEOUT_CYCLES in SHIFT, ACK or WAIT_IDLE, the block enters ERROR.
//  - The counter runs from clock release only; it is not restarted per bit.
//  - Timeout and fe in the same cycle: timeout wins.
//  Ready timing
//  - tx_ready=0 from the cycle after accept until the cycle after the tx_done/tx_error pulse.
//  - A new request is not accepted in the same cycle as a done or error pulse.
//  Invariants
//  - CLK_OE=1 only in INHIBIT and REQ.
//  - tx_done and tx_error are never high together.
//  - The bit counter is 4 bits and saturates; it never wraps.
// TESTING
//  Use a device model that generates a ~12 kHz PS2_CLK after seeing the request. The model
//  samples data on rising edges and ACKs by pulling data low on the 11th clock.
//  (INHIBIT_CYCLES=20, TIMEOUT_CYCLES=4000 for sim.)
//  1. Send 0xED → PS2_CLK low for 20 cycles.
//     Device samples start=0, bits 1,0,1,1,0,1,1,1, parity=1, stop=1.
//     Device ACKs → one tx_done pulse, tx_error=0.
//  2. Send 0xF4 → device sees parity=0.
//     Send 0x00 → device sees parity=1.
//     Send 0xFF → device sees parity=1. All three end in tx_done.
//  3. Device never clocks → tx_error pulse TIMEOUT_CYCLES cycles after the clock release.
//     Both OE=0 afterwards; tx_ready returns to 1.
//  4. Device omits the ACK (data stays high on the 11th clock) → tx_error pulse; no tx_done.
//  5. Assert RST during the 4th data bit → both OE=0 and tx_ready=1 immediately.
//     A following send of 0xF4 completes with tx_done.
//  6. Hold tx_valid high with new data while busy → only the first byte is sent.
//     The second byte is accepted only after tx_ready returns to 1.

Source files
------------

// File: rtl/ps2_host_tx.sv
`timescale 1ns/1ps
// ps2_host_tx
//   Host-to-device PS/2 transmitter. Sends one command byte to the keyboard
//   over the shared open-drain PS2_CLK / PS2_DATA lines. An OE output at 1
//   pulls its pad low; at 0 it releases the pad.
//
// Ports
//   CLK, RST        board clock, asynchronous active-high reset
//   tx_data[7:0]    command byte, captured when tx_valid & tx_ready
//   tx_valid        request to send tx_data
//   tx_ready        block idle, request can be accepted
//   busy            transfer in progress (~tx_ready); receiver must ignore the bus
//   tx_done         1-cycle pulse: byte sent and ACKed by the device
//   tx_error        1-cycle pulse: timeout or missing ACK
//   PS2_CLK         keyboard clock pad value (asynchronous)
//   PS2_DATA        keyboard data pad value (asynchronous)
//   PS2_CLK_OE      1 = pull PS2_CLK low
//   PS2_DATA_OE     1 = pull PS2_DATA low
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic       PS2_CLK_OE,
  output logic       PS2_DATA_OE
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] INH_PRE  = CNT_W'(INHIBIT_CYCLES - 2);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACK, S_WAIT_IDLE, S_ERROR
  } state_t;

  // Bit index stops at 15 instead of wrapping back to bit 0.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       bit_idx, bit_nxt;
  logic             data_oe, data_oe_nxt;
  logic             clk_oe, clk_oe_nxt;
  logic             accept;
  logic [7:0]       tx_byte;
  logic             parity;

  // Input synchroniser stage: p0 first flop, p1 synced value, p2 previous synced clock
  logic ps2_clk_p0, ps2_clk_p1, ps2_clk_p2;
  logic ps2_data_p0, ps2_data_p1;
  logic fe;

  // Reset to the idle-high line level so no false edge follows reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ps2_clk_p0  <= 1'b1;
      ps2_clk_p1  <= 1'b1;
      ps2_clk_p2  <= 1'b1;
      ps2_data_p0 <= 1'b1;
      ps2_data_p1 <= 1'b1;
    end else begin
      ps2_clk_p0  <= PS2_CLK;
      ps2_clk_p1  <= ps2_clk_p0;
      ps2_clk_p2  <= ps2_clk_p1;
      ps2_data_p0 <= PS2_DATA;
      ps2_data_p1 <= ps2_data_p0;
    end
  end

  assign fe = ps2_clk_p2 & ~ps2_clk_p1;

  assign tx_ready = (state == S_IDLE);
  assign busy     = ~tx_ready;
  assign accept   = tx_valid & tx_ready;

  // Captured byte and odd parity: data only, no reset needed
  always_ff @(posedge CLK) begin
    if (accept) begin
      tx_byte <= tx_data;
      parity  <= ~^tx_data;
    end
  end

  // FSM control register; OE outputs are registered so the pads never glitch
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      data_oe <= 1'b0;
      clk_oe  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_nxt;
      data_oe <= data_oe_nxt;
      clk_oe  <= clk_oe_nxt;
    end
  end

  assign PS2_CLK_OE  = clk_oe;
  assign PS2_DATA_OE = data_oe;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_nxt     = bit_idx;
    data_oe_nxt = data_oe;
    tx_done     = 1'b0;
    tx_error    = 1'b0;

    unique case (state)
      S_IDLE: begin
        data_oe_nxt = 1'b0;
        if (accept) begin
          state_nxt   = S_INHIBIT;
          cnt_nxt     = '0;
          // With a one-cycle inhibit the start bit must appear immediately.
          data_oe_nxt = (INHIBIT_CYCLES == 1);
        end
      end
      S_INHIBIT: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == INH_LAST) begin
          state_nxt   = S_REQ;
          data_oe_nxt = 1'b1;
        end else begin
          // Start bit goes low on the final inhibit cycle.
          data_oe_nxt = (cnt == INH_PRE);
        end
      end
      S_REQ: begin
        state_nxt   = S_SHIFT;
        cnt_nxt     = '0;
        bit_nxt     = '0;
        data_oe_nxt = 1'b1;
      end
      S_SHIFT, S_ACK, S_WAIT_IDLE: begin
        cnt_nxt = cnt + CNT_W'(1);
        // Timeout is checked first so it wins over a simultaneous edge.
        if (cnt == TO_LAST) begin
          state_nxt   = S_ERROR;
          data_oe_nxt = 1'b0;
        end else if (state == S_SHIFT) begin
          if (fe) begin
            if (bit_idx < 4'd8)       data_oe_nxt = ~tx_byte[bit_idx[2:0]];
            else if (bit_idx == 4'd8) data_oe_nxt = ~parity;
            else                      data_oe_nxt = 1'b0;
            bit_nxt = sat_inc4(bit_idx);
            if (bit_idx >= 4'd9) state_nxt = S_ACK;
          end
        end else if (state == S_ACK) begin
          data_oe_nxt = 1'b0;
          if (fe) state_nxt = ps2_data_p1 ? S_ERROR : S_WAIT_IDLE;
        end else begin
          if (ps2_clk_p1 && ps2_data_p1) begin
            tx_done   = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
      S_ERROR: begin
        tx_error    = 1'b1;
        data_oe_nxt = 1'b0;
        state_nxt   = S_IDLE;
      end
      default: begin
        state_nxt   = S_IDLE;
        data_oe_nxt = 1'b0;
      end
    endcase

    clk_oe_nxt = (state_nxt == S_INHIBIT) || (state_nxt == S_REQ);
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
// tb_ps2_host_tx
//   Directed bench for ps2_host_tx with a simple PS/2 device model on an
//   open-drain bus. The device clock is scaled down (60 CLK cycles per
//   PS/2 clock) to keep the run short.
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int TO   = 4000;
  localparam int HALF = 30;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, busy, tx_done, tx_error;
  logic       PS2_CLK_OE, PS2_DATA_OE;
  logic       dev_clk_low, dev_data_low;
  logic       ps2_clk_pad, ps2_data_pad;

  assign ps2_clk_pad  = ~(PS2_CLK_OE  | dev_clk_low);
  assign ps2_data_pad = ~(PS2_DATA_OE | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RST(RST), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .tx_done(tx_done), .tx_error(tx_error),
    .PS2_CLK(ps2_clk_pad), .PS2_DATA(ps2_data_pad),
    .PS2_CLK_OE(PS2_CLK_OE), .PS2_DATA_OE(PS2_DATA_OE)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, acc_cnt = 0;
  int oe_hi_cnt = 0, oe_both_cnt = 0;

  always @(posedge CLK) begin
    if (tx_done) done_cnt++;
    if (tx_error) err_cnt++;
    if (tx_done && tx_error) both_cnt++;
    if (tx_valid && tx_ready) acc_cnt++;
  end

  always @(negedge CLK) begin
    if (PS2_CLK_OE) oe_hi_cnt++;
    if (PS2_CLK_OE && PS2_DATA_OE) oe_both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    int n;
    n = 0;
    @(negedge CLK);
    while (!tx_ready && n < 6000) begin @(negedge CLK); n++; end
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge CLK);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!tx_ready && n < 6000) begin @(negedge CLK); n++; end
    check(tag, tx_ready, 1);
  endtask

  // Device: waits for the request, samples the start bit, then issues 11
  // clocks, sampling data on each rising edge; ACKs on the 11th clock.
  // rst_at != 0 asserts RST while the clock is low after that falling edge.
  task automatic dev_run(input bit ack, input int rst_at, output logic [10:0] frame);
    int n;
    frame = '0;
    n = 0;
    while (!PS2_CLK_OE && n < 100) begin @(negedge CLK); n++; end
    n = 0;
    while (PS2_CLK_OE && n < 1000) begin @(negedge CLK); n++; end
    check("dev_req_release", PS2_CLK_OE, 0);
    frame[0] = ps2_data_pad;
    for (int k = 1; k <= 11; k++) begin
      repeat (HALF / 2) @(negedge CLK);
      if (k == 11 && ack) dev_data_low = 1'b1;
      repeat (HALF - HALF / 2) @(negedge CLK);
      dev_clk_low = 1'b1;
      if (k == rst_at) begin
        repeat (8) @(negedge CLK);
        check("pre_rst_data_oe", PS2_DATA_OE, 1);
        #1 RST = 1'b1;
        #1;
        check("rst_clk_oe", PS2_CLK_OE, 0);
        check("rst_data_oe", PS2_DATA_OE, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        dev_clk_low = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        return;
      end
      repeat (HALF) @(negedge CLK);
      dev_clk_low = 1'b0;
      if (k <= 10) frame[k] = ps2_data_pad;
      if (k == 11) dev_data_low = 1'b0;
    end
  endtask

  logic [7:0]  t2_data [3] = '{8'hF4, 8'h00, 8'hFF};
  logic        t2_par  [3] = '{1'b0, 1'b1, 1'b1};

  initial begin
    logic [10:0] frame, fr_a, fr_b;
    int b_hi, b_both, d0, e0, a0, n, cyc;

    RST = 1'b1; tx_valid = 1'b0; tx_data = '0;
    dev_clk_low = 1'b0; dev_data_low = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_tx_ready", tx_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_clk_oe", PS2_CLK_OE, 0);
    check("reset_data_oe", PS2_DATA_OE, 0);
    check("reset_tx_done", tx_done, 0);
    check("reset_tx_error", tx_error, 0);
    RST = 1'b0;
    @(negedge CLK);

    // 1: 0xED, inhibit length, start bit overlap, frame and ACK
    b_hi = oe_hi_cnt; b_both = oe_both_cnt; d0 = done_cnt; e0 = err_cnt;
    send(8'hED);
    dev_run(1'b1, 0, frame);
    wait_idle("t1_idle");
    check("t1_clk_low_cycles", oe_hi_cnt - b_hi, INH + 1);
    check("t1_start_overlap", oe_both_cnt - b_both, 2);
    check("t1_frame", frame, {1'b1, 1'b1, 8'hED, 1'b0});
    check("t1_done", done_cnt - d0, 1);
    check("t1_error", err_cnt - e0, 0);

    // 2: parity variants
    for (int i = 0; i < 3; i++) begin
      d0 = done_cnt;
      send(t2_data[i]);
      dev_run(1'b1, 0, frame);
      wait_idle("t2_idle");
      check("t2_frame", frame, {1'b1, t2_par[i], t2_data[i], 1'b0});
      check("t2_done", done_cnt - d0, 1);
    end

    // 3: device never clocks
    d0 = done_cnt; e0 = err_cnt;
    send(8'h3C);
    n = 0;
    while (PS2_CLK_OE && n < 100) begin @(negedge CLK); n++; end
    cyc = 0;
    while (!tx_error && cyc < TO + 1000) begin @(negedge CLK); cyc++; end
    check("t3_timeout_cycles", cyc, TO);
    @(negedge CLK);
    check("t3_clk_oe", PS2_CLK_OE, 0);
    check("t3_data_oe", PS2_DATA_OE, 0);
    check("t3_tx_ready", tx_ready, 1);
    check("t3_error", err_cnt - e0, 1);
    check("t3_done", done_cnt - d0, 0);

    // 4: missing ACK
    d0 = done_cnt; e0 = err_cnt;
    send(8'hF4);
    dev_run(1'b0, 0, frame);
    wait_idle("t4_idle");
    check("t4_frame", frame, {1'b1, 1'b0, 8'hF4, 1'b0});
    check("t4_error", err_cnt - e0, 1);
    check("t4_done", done_cnt - d0, 0);

    // 5: reset during the 4th data bit, then a clean send
    send(8'h00);
    dev_run(1'b1, 4, frame);
    d0 = done_cnt;
    send(8'hF4);
    dev_run(1'b1, 0, frame);
    wait_idle("t5_idle");
    check("t5_frame", frame, {1'b1, 1'b0, 8'hF4, 1'b0});
    check("t5_done", done_cnt - d0, 1);

    // 6: tx_valid held with new data while busy
    a0 = acc_cnt;
    n = 0;
    while (!tx_ready && n < 100) begin @(negedge CLK); n++; end
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    @(negedge CLK);
    tx_data = 8'h5A;
    dev_run(1'b1, 0, fr_a);
    n = 0;
    while (!tx_done && n < 200) begin @(negedge CLK); n++; end
    check("t6_ready_in_done_cycle", tx_ready, 0);
    check("t6_accepts_while_busy", acc_cnt - a0, 1);
    @(negedge CLK);
    check("t6_ready_after_done", tx_ready, 1);
    @(negedge CLK);
    tx_valid = 1'b0;
    dev_run(1'b1, 0, fr_b);
    wait_idle("t6_idle");
    check("t6_frame_a", fr_a, {1'b1, 1'b1, 8'hA5, 1'b0});
    check("t6_frame_b", fr_b, {1'b1, 1'b1, 8'h5A, 1'b0});
    check("t6_accepts_total", acc_cnt - a0, 2);

    check("done_error_exclusive", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
